// File: rtl/fp_pkg.sv
// Shared floating-point definitions: flag bit positions, multiplier FSM states
// and the ALU op_code encodings.
package fp_pkg;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_PACK
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_code_t;

  function automatic logic [4:0] mk_flags(input logic nv, input logic of,
                                          input logic uf, input logic nx);
    logic [4:0] f;
    f          = '0;
    f[FLAG_NV] = nv;
    f[FLAG_DZ] = 1'b0;  // a multiply never divides by zero
    f[FLAG_OF] = of;
    f[FLAG_UF] = uf;
    f[FLAG_NX] = nx;
    return f;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; subnormals are reported as zero (DAZ).
module fp_classify #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0]   i_op,
  output logic           o_sign,
  output logic           o_is_zero,
  output logic           o_is_inf,
  output logic           o_is_nan,
  output logic           o_is_snan,
  output logic [MAN_W:0] o_sig
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_frac;
  logic             w_exp_ones;

  assign w_exp      = i_op[W-2 -: EXP_W];
  assign w_frac     = i_op[MAN_W-1:0];
  assign w_exp_ones = &w_exp;

  assign o_sign    = i_op[W-1];
  assign o_is_zero = (w_exp == '0);
  assign o_is_inf  = w_exp_ones & (w_frac == '0);
  assign o_is_nan  = w_exp_ones & (w_frac != '0);
  assign o_is_snan = o_is_nan & ~w_frac[MAN_W-1];
  assign o_sig     = {~o_is_zero, w_frac};

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-style multiplier: special-case early exit, one-bit-per-cycle
// shift-add significand product, normalise, round-to-nearest-even, pack.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  output logic         o_busy,
  output logic [W-1:0] o_result,
  output logic [4:0]   o_flags,
  output logic         o_valid_out
);

  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(SW + 1);
  localparam logic signed [EW-1:0] EXP_BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]        EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [W-2:0]         INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t                r_state;
  logic [W-1:0]          r_a, r_b, r_res;
  logic [4:0]            r_flg;
  logic [PW-1:0]         r_prod, r_mcand;
  logic [SW-1:0]         r_mplier;
  logic signed [EW-1:0]  r_exp;
  logic [CW-1:0]         r_cnt;
  logic                  r_sign;

  logic                  w_sign_a, w_zero_a, w_inf_a, w_nan_a, w_snan_a;
  logic                  w_sign_b, w_zero_b, w_inf_b, w_nan_b, w_snan_b;
  logic [SW-1:0]         w_sig_a, w_sig_b;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .i_op(r_a), .o_sign(w_sign_a), .o_is_zero(w_zero_a), .o_is_inf(w_inf_a),
    .o_is_nan(w_nan_a), .o_is_snan(w_snan_a), .o_sig(w_sig_a)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .i_op(r_b), .o_sign(w_sign_b), .o_is_zero(w_zero_b), .o_is_inf(w_inf_b),
    .o_is_nan(w_nan_b), .o_is_snan(w_snan_b), .o_sig(w_sig_b)
  );

  logic                  w_sign, w_special;
  logic [W-1:0]          w_sp_res;
  logic [4:0]            w_sp_flg;

  always_comb begin
    w_sign    = w_sign_a ^ w_sign_b;
    w_special = 1'b1;
    w_sp_res  = QNAN;
    w_sp_flg  = '0;
    if (w_nan_a | w_nan_b)
      w_sp_flg = mk_flags(w_snan_a | w_snan_b, 1'b0, 1'b0, 1'b0);
    else if ((w_inf_a & w_zero_b) | (w_zero_a & w_inf_b))
      w_sp_flg = mk_flags(1'b1, 1'b0, 1'b0, 1'b0);
    else if (w_inf_a | w_inf_b)
      w_sp_res = {w_sign, INF_MAG};
    else if (w_zero_a | w_zero_b)
      w_sp_res = {w_sign, {(W-1){1'b0}}};
    else
      w_special = 1'b0;
  end

  // Product is normalised with its leading one at bit PW-2 before rounding.
  logic [SW-1:0]         w_mant;
  logic [SW:0]           w_mant_r;
  logic [MAN_W-1:0]      w_frac;
  logic                  w_guard, w_sticky, w_round_up, w_carry, w_ovf, w_unf;
  logic signed [EW-1:0]  w_exp_r;
  logic [W-1:0]          w_rnd_res;
  logic [4:0]            w_rnd_flg;

  always_comb begin
    w_mant     = r_prod[PW-2 -: SW];
    w_guard    = r_prod[MAN_W-1];
    w_sticky   = |r_prod[MAN_W-2:0];
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_mant_r   = {1'b0, w_mant} + {{SW{1'b0}}, w_round_up};
    w_carry    = w_mant_r[SW];
    w_frac     = w_carry ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
    w_exp_r    = w_carry ? r_exp + EW'(1) : r_exp;
    w_ovf      = !w_exp_r[EW-1] && ($unsigned(w_exp_r) >= EXP_MAX);
    w_unf      = w_exp_r[EW-1] || (w_exp_r == '0);
    w_rnd_res  = {r_sign, w_exp_r[EXP_W-1:0], w_frac};
    w_rnd_flg  = mk_flags(1'b0, 1'b0, 1'b0, w_guard | w_sticky);
    if (w_ovf) begin
      w_rnd_res = {r_sign, INF_MAG};
      w_rnd_flg = mk_flags(1'b0, 1'b1, 1'b0, 1'b1);
    end else if (w_unf) begin
      w_rnd_res = {r_sign, {(W-1){1'b0}}};
      w_rnd_flg = mk_flags(1'b0, 1'b0, 1'b1, 1'b1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_flg       <= '0;
      r_prod      <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_exp       <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      o_busy      <= 1'b0;
      o_result    <= '0;
      o_flags     <= '0;
      o_valid_out <= 1'b0;
    end else begin
      o_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_a     <= i_op_a;
          r_b     <= i_op_b;
          o_busy  <= 1'b1;
          r_state <= S_CHECK;
        end
        S_CHECK: if (w_special) begin
          r_res   <= w_sp_res;
          r_flg   <= w_sp_flg;
          r_state <= S_PACK;
        end else begin
          r_sign   <= w_sign;
          r_exp    <= $signed({2'b00, r_a[W-2 -: EXP_W]}) + $signed({2'b00, r_b[W-2 -: EXP_W]}) - EXP_BIAS;
          r_mcand  <= {{SW{1'b0}}, w_sig_a};
          r_mplier <= w_sig_b;
          r_prod   <= '0;
          r_cnt    <= '0;
          r_state  <= S_MUL;
        end
        S_MUL: begin
          r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(MAN_W)) r_state <= S_NORM;
        end
        S_NORM: begin
          // Fold the bit shifted out into the LSB so the sticky OR still sees it.
          if (r_prod[PW-1]) begin
            r_prod <= {1'b0, r_prod[PW-1:2], r_prod[1] | r_prod[0]};
            r_exp  <= r_exp + EW'(1);
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_res   <= w_rnd_res;
          r_flg   <= w_rnd_flg;
          r_state <= S_PACK;
        end
        S_PACK: begin
          o_result    <= r_res;
          o_flags     <= r_flg;
          o_valid_out <= 1'b1;
          o_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Parametrised-format sequential floating-point multiplier with start/valid handshake, sharing the op/flag conventions of the FP ALU. It generalises the fixed half-precision datapath to any IEEE-754-style format (EXP_W, MAN_W) and resolves the limit cases (NaN, Inf, zero, overflow, underflow) with an early-exit path. The mantissa product uses an iterative shift-add loop, one multiplier bit per cycle, which keeps area small. It sits beside the ALU as its multiply engine; the integration layer multiplexes results by op_code.

## Interface
- EXP_W, 5, exponent width; BIAS = 2^(EXP_W-1)-1 is derived.
- MAN_W, 10, stored fraction width; W = 1+EXP_W+MAN_W is derived (16 by default, 32 for EXP_W=8, MAN_W=23).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_a, op_b  in  W  operands, packed {sign, exp, frac}.
- busy  out  1  high whenever state != IDLE.
- result  out  W  product; holds until the next completion.
- flags  out  5  {NV, DZ, OF, UF, NX} in bits 4..0; DZ is always 0; holds with result.
- valid_out  out  1  one-cycle pulse when result/flags update.

## Operation
- States are IDLE, CHECK, MUL, NORM, ROUND and PACK.
- IDLE → CHECK: on start=1. The operands are captured on that edge.
- CHECK (1 cycle): classify both operands.
  - A special case goes to PACK.
  - Otherwise go to MUL.
- MUL (MAN_W+1 cycles): shift-add of the {1,frac} significands into a 2*(MAN_W+1)-bit product.
- NORM → ROUND → PACK → IDLE.
- Classification:
  - Exp all-ones with frac=0 is Inf.
  - Exp all-ones with frac≠0 is NaN. It is signalling when the frac MSB is 0.
  - Exp=0 is zero; subnormal inputs are treated as zero (DAZ).
- Special cases, in priority order:
  - Any NaN → canonical qNaN {0, all-ones, 1, 0…} (0x7E00 for fp16). NV is set iff either operand is an sNaN.
  - Inf × zero → canonical qNaN, with NV.
  - Inf × (Inf or finite) → Inf with sign = sa^sb, flags 0.
  - Zero × finite → signed zero, flags 0.
- Normal path:
  - sign = sa^sb; exponent e = ea+eb-BIAS, computed in EXP_W+2 bits, signed.
  - NORM: if the product MSB is set, shift right 1 and e+1.
  - ROUND: round to nearest, ties to even, using the guard bit and the sticky OR of all lower bits. A mantissa carry-out gives e+1.
  - NX = any discarded bit is nonzero.
  - If e ≥ 2^EXP_W-1 → signed Inf, with OF|NX.
  - If e ≤ 0 → signed zero (flush-to-zero, FTZ), with UF|NX.
- Only one operation is in flight at a time.

## Timing
- Reset state:
  - state = IDLE.
  - result, flags, busy and valid_out are all 0.
  - The internal product, exponent and counter registers are cleared.
- Reset asserted mid-operation aborts the operation: no valid_out pulse, result is 0 on the next cycle.
- Latency counts clock edges from the edge that samples start to the edge that raises valid_out.
  - Special path: 2.
  - Normal path: MAN_W+5 (15 for fp16, 28 for fp32).
- busy rises on the edge that samples start. It falls on the same edge that raises valid_out.
- start while busy=1 is ignored; it is neither queued nor does it corrupt the operation in flight.
- start in the same cycle valid_out is high is accepted, because the state is already IDLE. This gives back-to-back throughput of one operation per latency period.
- The operands need only be valid in the start cycle.

## Structure
- The shared package `fp_pkg` holds:
  - the flag bit-index constants (FLAG_NV=4 … FLAG_NX=0);
  - the state enum;
  - the op_code encodings used by the ALU (00 add, 01 sub, 10 mul, 11 div).
- Sub-module `fp_classify` is combinational and parametrised by EXP_W/MAN_W. There is one instance per operand.
  - Outputs: is_zero, is_inf, is_nan, is_snan, and the significand with the hidden bit.

## Test plan
- fp16 0x3C00 × 0x4000 → result 0x4000, flags 0, valid_out exactly 15 edges after start. Also 0xC000 × 0x3C00 → 0xC000, flags 0.
- 0x7BFF × 0x7BFF → 0x7C00, flags 5'b00101 (OF, NX). 0x0400 × 0x0400 → 0x0000, flags 5'b00011 (UF, NX).
- 0x7C00 × 0x0000 → 0x7E00, flags 5'b10000, latency 2. 0x7E00 × 0x3C00 → 0x7E00, flags 0. 0x7D00 × 0x3C00 → 0x7E00, flags 5'b10000.
- Rounding: 0x3C01 × 0x3C01 → 0x3C02, flags 5'b00001.
- Control:
  - A second start during busy is ignored; the first result still arrives at edge 15.
  - rst=0 at edge 7 of an operation → no valid_out; outputs are 0.
  - start in the valid_out cycle → the next result arrives 15 edges later.
- Instance with EXP_W=8, MAN_W=23: 0x3F800000 × 0x40000000 → 0x40000000, flags 0, latency 28. 0x7F7FFFFF × 0x7F7FFFFF → 0x7F800000, flags 5'b00101.
